wishbone_slave_mem: RTL and testbench

WISHBONE_SLAVE_MEM -- requirements
Module: wishbone_slave_mem

---
 rtl/wishbone_slave_mem.sv | 241 ++++++++++++++++++++++++
 tb/tb_wishbone_slave_mem.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_mem.sv
// -----------------------------------------------------------------------------
// wishbone_slave_mem
//   Wishbone B4 slave with a word-organised memory.
//
//   Every beat gets exactly one termination: RTY_O when the slave is busy, ERR_O
//   for an out-of-range or misaligned address, and ACK_O otherwise. A new bus
//   cycle first waits WAIT_CYC clocks. After that, incrementing or
//   constant-address bursts are acknowledged back-to-back. The memory and the
//   beat counters clear asynchronously on RST_I.
//
// Ports
//   CLK_I   : clock
//   RST_I   : asynchronous reset, active-high
//   ADR_I   : byte address; word index = (ADR_I - BASE_ADDR) >> 2
//   DAT_I   : write data
//   DAT_O   : read data; valid only in a read ACK_O cycle, zero otherwise
//   SEL_I   : byte lane enables for writes
//   WE_I    : 1 = write, 0 = read
//   STB_I   : strobe
//   CYC_I   : bus cycle
//   CTI_I   : cycle type (001 const burst, 010 incr burst, other = end/classic)
//   BTE_I   : burst type extension, not used by this slave
//   ACK_O   : normal termination
//   ERR_O   : error termination
//   RTY_O   : retry termination
//   busy_i  : slave busy, forces RTY_O
//   ack_cnt : running count of ACK_O beats (wraps)
//   err_cnt : running count of ERR_O beats (wraps)
// -----------------------------------------------------------------------------
module wishbone_slave_mem #(
  parameter int unsigned          WB_ADDR_W = 32,
  parameter int unsigned          WB_DATA_W = 32,
  parameter int unsigned          MEM_DEPTH = 64,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR = {WB_ADDR_W{1'b0}},
  parameter int unsigned          WAIT_CYC  = 1
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [WB_ADDR_W-1:0]   ADR_I,
  input  logic [WB_DATA_W-1:0]   DAT_I,
  output logic [WB_DATA_W-1:0]   DAT_O,
  input  logic [WB_DATA_W/8-1:0] SEL_I,
  input  logic                   WE_I,
  input  logic                   STB_I,
  input  logic                   CYC_I,
  input  logic [2:0]             CTI_I,
  input  logic [1:0]             BTE_I,
  output logic                   ACK_O,
  output logic                   ERR_O,
  output logic                   RTY_O,
  input  logic                   busy_i,
  output logic [15:0]            ack_cnt,
  output logic [15:0]            err_cnt
);

  localparam int unsigned SEL_W = WB_DATA_W / 8;
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Memory span in bytes. It is one bit wider than the address, so the top of
  // the span cannot overflow.
  localparam logic [WB_ADDR_W:0] MEM_BYTES = (WB_ADDR_W + 1)'(MEM_DEPTH * 4);

  // Value loaded into the wait counter on leaving IDLE. The counter counts
  // down to zero, so it holds the number of WAIT cycles minus one.
  localparam bit       HAS_WAIT  = (WAIT_CYC != 32'd0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYC - 32'd1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [3:0]           wait_r;
  logic [3:0]           wait_nxt_s;

  logic [WB_DATA_W-1:0] mem_r [MEM_DEPTH];

  logic                 req_s;
  logic                 burst_s;
  logic [WB_ADDR_W:0]   offset_s;
  logic                 in_range_s;
  logic                 aligned_s;
  logic                 addr_ok_s;
  logic [IDX_W-1:0]     index_s;
  logic                 ack_s;
  logic                 err_s;
  logic                 rty_s;
  logic [15:0]          ack_cnt_r;
  logic [15:0]          err_cnt_r;

  // BTE_I is informational only. It is folded here so that it is still
  // consumed.
  logic                 unused_s;
  assign unused_s = ^BTE_I;

  assign req_s = CYC_I & STB_I;

  // Only constant and incrementing bursts keep the FSM in RESP. Values 011..110
  // behave like a classic cycle.
  assign burst_s = (CTI_I == 3'b001) || (CTI_I == 3'b010);

  // Address decode. The subtraction is one bit wider than the address. The
  // borrow bit flags addresses below BASE_ADDR.
  assign offset_s   = {1'b0, ADR_I} - {1'b0, BASE_ADDR};
  assign in_range_s = ~offset_s[WB_ADDR_W] & (offset_s < MEM_BYTES);
  assign aligned_s  = (ADR_I[1:0] == 2'b00);
  assign addr_ok_s  = in_range_s & aligned_s;
  assign index_s    = offset_s[IDX_W+1:2];

  // State register and wait counter.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r <= IDLE;
      wait_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

  // Next-state logic and wait-counter update.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (HAS_WAIT) begin
            state_nxt_s = WAIT;
            wait_nxt_s  = WAIT_LOAD;
          end else begin
            state_nxt_s = RESP;
            wait_nxt_s  = 4'd0;
          end
        end else begin
          state_nxt_s = IDLE;
          wait_nxt_s  = 4'd0;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
          wait_nxt_s  = 4'd0;
        end else if (wait_r == 4'd0) begin
          state_nxt_s = RESP;
          wait_nxt_s  = 4'd0;
        end else begin
          state_nxt_s = WAIT;
          wait_nxt_s  = wait_r - 4'd1;
        end
      end
      RESP: begin
        wait_nxt_s = 4'd0;
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (ack_s && burst_s) begin
          state_nxt_s = RESP;
        end else begin
          // Classic or end-of-burst ACK, or any ERR/RTY, ends the bus cycle.
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        wait_nxt_s  = 4'd0;
      end
    endcase
  end

  // Beat termination: busy has priority over address errors, which have
  // priority over ACK.
  always_comb begin
    ack_s = 1'b0;
    err_s = 1'b0;
    rty_s = 1'b0;
    if ((state_r == RESP) && req_s) begin
      if (busy_i) begin
        rty_s = 1'b1;
      end else if (!addr_ok_s) begin
        err_s = 1'b1;
      end else begin
        ack_s = 1'b1;
      end
    end else begin
      ack_s = 1'b0;
      err_s = 1'b0;
      rty_s = 1'b0;
    end
  end

  // Read data is presented only alongside a read ACK.
  always_comb begin
    DAT_O = {WB_DATA_W{1'b0}};
    if (ack_s && !WE_I) begin
      DAT_O = mem_r[index_s];
    end else begin
      DAT_O = {WB_DATA_W{1'b0}};
    end
  end

  assign ACK_O = ack_s;
  assign ERR_O = err_s;
  assign RTY_O = rty_s;

  // Memory array. Only acknowledged writes update it, one byte lane at a time.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_r[i] <= {WB_DATA_W{1'b0}};
      end
    end else if (ack_s && WE_I) begin
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (SEL_I[b]) begin
          mem_r[index_s][8*b +: 8] <= DAT_I[8*b +: 8];
        end
      end
    end
  end

  // Beat counters. They wrap naturally at 16 bits.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_cnt_r <= 16'd0;
      err_cnt_r <= 16'd0;
    end else begin
      if (ack_s) begin
        ack_cnt_r <= ack_cnt_r + 16'd1;
      end
      if (err_s) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign ack_cnt = ack_cnt_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_wishbone_slave_mem
//   Self-checking bench for wishbone_slave_mem.
//
//   The reference model works per beat. A beat that starts a bus cycle sees
//   WAIT+1 quiet cycles before its termination. A beat that follows an
//   acknowledged burst beat terminates immediately. The kind of termination
//   follows the busy/range/alignment priority. A single negedge process
//   compares every DUT output against the expected values for the current
//   cycle.
// -----------------------------------------------------------------------------
module tb_wishbone_slave_mem;

  localparam int          DEPTH = 64;
  localparam int          WAITC = 1;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] ADR_I = 32'd0;
  logic [31:0] DAT_I = 32'd0;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_I = 4'd0;
  logic        WE_I  = 1'b0;
  logic        STB_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic [2:0]  CTI_I = 3'd0;
  logic [1:0]  BTE_I = 2'd0;
  logic        ACK_O;
  logic        ERR_O;
  logic        RTY_O;
  logic        busy_i = 1'b0;
  logic [15:0] ack_cnt;
  logic [15:0] err_cnt;

  always #5 CLK_I = ~CLK_I;

  wishbone_slave_mem #(
    .WB_ADDR_W(32),
    .WB_DATA_W(32),
    .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_CYC (WAITC)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .SEL_I  (SEL_I),
    .WE_I   (WE_I),
    .STB_I  (STB_I),
    .CYC_I  (CYC_I),
    .CTI_I  (CTI_I),
    .BTE_I  (BTE_I),
    .ACK_O  (ACK_O),
    .ERR_O  (ERR_O),
    .RTY_O  (RTY_O),
    .busy_i (busy_i),
    .ack_cnt(ack_cnt),
    .err_cnt(err_cnt)
  );

  // Reference model state.
  logic [31:0] mdl_mem [DEPTH];
  int unsigned mdl_ack_cnt;
  int unsigned mdl_err_cnt;
  bit          chained;

  // Expected outputs for the cycle currently on the bus.
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_rty = 1'b0;
  logic [31:0] exp_dat = 32'd0;
  logic [15:0] exp_ack_cnt = 16'd0;
  logic [15:0] exp_err_cnt = 16'd0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cap_dat  = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      chk("ACK_O",   32'(ACK_O),   32'(exp_ack));
      chk("ERR_O",   32'(ERR_O),   32'(exp_err));
      chk("RTY_O",   32'(RTY_O),   32'(exp_rty));
      chk("DAT_O",   DAT_O,        exp_dat);
      chk("ack_cnt", 32'(ack_cnt), 32'(exp_ack_cnt));
      chk("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
      if (ACK_O && !WE_I) begin
        cap_dat = DAT_O;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    mdl_ack_cnt = 0;
    mdl_err_cnt = 0;
    chained     = 1'b0;
  endtask

  // Drive one bus cycle and publish its expected outputs, then step past the edge.
  task automatic drive(input logic cyc, input logic stb, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic we,
                       input logic [2:0] cti, input logic busy, input logic ea,
                       input logic ee, input logic er, input logic [31:0] ed);
    CYC_I  = cyc;
    STB_I  = stb;
    ADR_I  = adr;
    DAT_I  = dat;
    SEL_I  = sel;
    WE_I   = we;
    CTI_I  = cti;
    busy_i = busy;
    BTE_I  = 2'($urandom_range(0, 3));
    exp_ack     = ea;
    exp_err     = ee;
    exp_rty     = er;
    exp_dat     = ed;
    exp_ack_cnt = 16'(mdl_ack_cnt);
    exp_err_cnt = 16'(mdl_err_cnt);
    @(posedge CLK_I);
    #1;
  endtask

  // One beat: quiet cycles (unless chained), then the termination cycle.
  task automatic beat(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic [2:0] cti, input logic busy);
    int          quiet;
    bit          inr;
    bit          t_ack;
    bit          t_err;
    bit          t_rty;
    int          idx;
    logic [31:0] ed;
    logic [63:0] a64;
    quiet = chained ? 0 : WAITC + 1;
    for (int i = 0; i < quiet; i++) begin
      drive(1'b1, 1'b1, adr, dat, sel, we, cti, busy, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    a64   = {32'd0, adr};
    inr   = (a64 >= {32'd0, BASE}) && (a64 < {32'd0, BASE} + 64'(4 * DEPTH));
    idx   = inr ? int'((adr - BASE) >> 2) : 0;
    t_rty = busy;
    t_err = !busy && (!inr || (adr % 32'd4) != 32'd0);
    t_ack = !busy && !t_err;
    ed    = (t_ack && !we) ? mdl_mem[idx] : 32'd0;
    drive(1'b1, 1'b1, adr, dat, sel, we, cti, busy, t_ack, t_err, t_rty, ed);
    if (t_ack) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) mdl_mem[idx][8*b +: 8] = dat[8*b +: 8];
        end
      end
      mdl_ack_cnt = (mdl_ack_cnt + 1) % 65536;
    end else if (t_err) begin
      mdl_err_cnt = (mdl_err_cnt + 1) % 65536;
    end
    chained = t_ack && (cti == 3'b001 || cti == 3'b010);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, 1'b0, 32'd0);
    end
    chained = 1'b0;
  endtask

  // Strobe raised for k cycles and dropped before any termination may appear.
  task automatic abort_cycle(input int k);
    if (chained) idle(1);
    for (int i = 0; i < k; i++) begin
      drive(1'b1, 1'b1, BASE, $urandom, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    idle(1);
  endtask

  function automatic logic [31:0] rand_adr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80)      return BASE + 32'($urandom_range(0, 15)) * 32'd4;
    else if (r < 87) return BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
    else if (r < 94) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64)) * 32'd4;
    else             return BASE - 32'($urandom_range(1, 16)) * 32'd4;
  endfunction

  initial begin
    logic [2:0] end_cti [6];
    end_cti[0] = 3'b000; end_cti[1] = 3'b011; end_cti[2] = 3'b100;
    end_cti[3] = 3'b101; end_cti[4] = 3'b110; end_cti[5] = 3'b111;
    model_reset();

    // Reset state.
    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_ack",     32'(ACK_O),   32'd0);
    chk("rst_err",     32'(ERR_O),   32'd0);
    chk("rst_rty",     32'(RTY_O),   32'd0);
    chk("rst_dat",     DAT_O,        32'd0);
    chk("rst_ack_cnt", 32'(ack_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    RST_I = 1'b0;

    // Classic write then read of the same word.
    beat(BASE + 32'd8, 32'hA5A5_5A5A, 4'hF, 1'b1, 3'b000, 1'b0);
    beat(BASE + 32'd8, 32'h0,         4'hF, 1'b0, 3'b000, 1'b0);
    idle(1);
    chk("classic_rd_dat",  cap_dat,      32'hA5A5_5A5A);
    chk("classic_ack_cnt", 32'(ack_cnt), 32'd2);

    // Byte-lane merge.
    beat(BASE + 32'd16, 32'h1122_3344, 4'hF,    1'b1, 3'b000, 1'b0);
    beat(BASE + 32'd16, 32'hFFFF_FFFF, 4'b0101, 1'b1, 3'b000, 1'b0);
    beat(BASE + 32'd16, 32'h0,         4'hF,    1'b0, 3'b000, 1'b0);
    idle(2);
    chk("sel_merge_dut", cap_dat,    32'h11FF_33FF);
    chk("sel_merge_mdl", mdl_mem[4], 32'h11FF_33FF);

    // Incrementing burst of four reads after four classic writes.
    for (int i = 0; i < 4; i++) begin
      beat(BASE + 32'd32 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 3'b000, 1'b0);
    end
    beat(BASE + 32'd32, 32'd0, 4'hF, 1'b0, 3'b010, 1'b0);
    beat(BASE + 32'd36, 32'd0, 4'hF, 1'b0, 3'b010, 1'b0);
    beat(BASE + 32'd40, 32'd0, 4'hF, 1'b0, 3'b010, 1'b0);
    beat(BASE + 32'd44, 32'd0, 4'hF, 1'b0, 3'b111, 1'b0);
    chk("burst_last_dat", cap_dat, 32'hC0DE_0003);
    // The FSM must be back in IDLE: a following beat waits again.
    beat(BASE + 32'd36, 32'd0, 4'hF, 1'b0, 3'b000, 1'b0);
    idle(1);
    chk("burst_ack_cnt", 32'(ack_cnt), 32'd14);

    // Out-of-range and misaligned accesses.
    beat(BASE + 32'(4 * DEPTH), 32'd0, 4'hF, 1'b0, 3'b000, 1'b0);
    beat(BASE + 32'd2,          32'hDEAD_0000, 4'hF, 1'b1, 3'b000, 1'b0);
    idle(1);
    chk("err_cnt_two",   32'(err_cnt), 32'd2);
    chk("err_ack_still", 32'(ack_cnt), 32'd14);

    // Last word in range, and a busy write that must be retried.
    beat(BASE + 32'(4 * (DEPTH - 1)), 32'h7777_8888, 4'hF, 1'b1, 3'b000, 1'b0);
    beat(BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b000, 1'b1);
    beat(BASE + 32'd8, 32'd0,         4'hF, 1'b0, 3'b000, 1'b0);
    idle(1);
    chk("retry_mem_kept", cap_dat, 32'hA5A5_5A5A);
    beat(BASE + 32'(4 * (DEPTH - 1)), 32'd0, 4'hF, 1'b0, 3'b000, 1'b0);
    idle(1);
    chk("last_word_dat", cap_dat, 32'h7777_8888);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idle($urandom_range(1, 3));
      end else if (r == 1) begin
        abort_cycle($urandom_range(1, WAITC + 1));
      end else if (r < 6) begin
        beat(rand_adr(), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             end_cti[$urandom_range(0, 5)], ($urandom_range(0, 9) == 0));
      end else begin
        int         len;
        logic [2:0] bcti;
        logic [31:0] a;
        len  = $urandom_range(2, 5);
        bcti = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
        a    = rand_adr();
        for (int k = 0; k < len; k++) begin
          beat(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               (k == len - 1) ? (($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000) : bcti,
               ($urandom_range(0, 9) == 0));
          if (bcti == 3'b010) a = a + 32'd4;
        end
      end
    end
    idle(2);

    // Reset pulse in the middle of a burst.
    beat(BASE + 32'd8,  32'd0, 4'hF, 1'b0, 3'b010, 1'b0);
    beat(BASE + 32'd12, 32'd0, 4'hF, 1'b0, 3'b010, 1'b0);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = BASE + 32'd16; CTI_I = 3'b010;
    busy_i = 1'b0;
    #1;
    RST_I = 1'b1;
    #1;
    chk("midrst_ack",     32'(ACK_O),   32'd0);
    chk("midrst_err",     32'(ERR_O),   32'd0);
    chk("midrst_rty",     32'(RTY_O),   32'd0);
    chk("midrst_dat",     DAT_O,        32'd0);
    chk("midrst_ack_cnt", 32'(ack_cnt), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0;
    @(posedge CLK_I);
    @(posedge CLK_I);
    #1;
    model_reset();
    RST_I = 1'b0;
    // The first beat after release starts from IDLE; the memory reads back zero.
    beat(BASE + 32'd8,  32'd0, 4'hF, 1'b0, 3'b000, 1'b0);
    beat(BASE + 32'd16, 32'd0, 4'hF, 1'b0, 3'b000, 1'b0);
    idle(1);
    chk("postrst_dat",     cap_dat,      32'd0);
    chk("postrst_ack_cnt", 32'(ack_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
